// File: rtl/conv_read_addr_gen.sv
// conv_read_addr_gen: walks IF/filter scratchpads tap by tap over every sliding window of a row
module conv_read_addr_gen #(
   parameter int IF_ADDR_LEN   = 4,
   parameter int FILT_ADDR_LEN = 4,
   parameter int STRIDE_W      = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     start_rd_gen,
   input  logic [FILT_ADDR_LEN-1:0] filt_len,
   input  logic [STRIDE_W-1:0]      stride,
   input  logic [IF_ADDR_LEN:0]     if_len,
   input  logic [IF_ADDR_LEN:0]     if_wr_cnt,
   input  logic                     stall,
   output logic                     rd_en,
   output logic [IF_ADDR_LEN-1:0]   if_raddr,
   output logic [FILT_ADDR_LEN-1:0] filt_raddr,
   output logic                     first_mac,
   output logic                     psum_done,
   output logic                     stride_pos_ld,
   output logic                     full_done,
   output logic [IF_ADDR_LEN-1:0]   win_idx,
   output logic                     busy
);
   localparam int XW = IF_ADDR_LEN + 2;
   typedef enum logic [1:0] {IDLE, READ, ADVANCE, DONE} state_t;
   state_t                   state_q, state_d;
   logic [IF_ADDR_LEN:0]     base_q, base_d, n_q, n_d;
   logic [FILT_ADDR_LEN-1:0] tap_q, tap_d, k_q, k_d;
   logic [STRIDE_W-1:0]      s_q, s_d;
   logic [IF_ADDR_LEN-1:0]   win_q, win_d;
   logic [XW-1:0]            pos;
   logic                     avail, cfg_ok, last_win;
   always_comb begin
      pos           = XW'(base_q) + XW'(tap_q);
      avail         = pos < XW'(if_wr_cnt);
      cfg_ok        = (filt_len != '0) && (stride != '0) && (XW'(filt_len) <= XW'(if_len));
      last_win      = XW'(base_q) + XW'(s_q) + XW'(k_q) > XW'(n_q);
      busy          = state_q != IDLE;
      rd_en         = ~clear & (state_q == READ) & ~stall & avail;
      if_raddr      = (state_q == READ) ? pos[IF_ADDR_LEN-1:0] : '0;
      filt_raddr    = (state_q == READ) ? tap_q : '0;
      first_mac     = rd_en & (tap_q == '0);
      psum_done     = rd_en & (tap_q == k_q - FILT_ADDR_LEN'(1));
      stride_pos_ld = ~clear & (state_q == ADVANCE);
      full_done     = ~clear & (state_q == DONE);
      win_idx       = busy ? win_q : '0;
   end
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      tap_d   = tap_q;
      win_d   = win_q;
      k_d     = k_q;
      s_d     = s_q;
      n_d     = n_q;
      if (clear) begin
         state_d = IDLE;
         base_d  = '0;
         tap_d   = '0;
         win_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (start_rd_gen) begin
               state_d = cfg_ok ? READ : DONE;
               k_d     = filt_len;
               s_d     = stride;
               n_d     = if_len;
               base_d  = '0;
               tap_d   = '0;
               win_d   = '0;
            end
            READ: if (rd_en) begin
               tap_d = tap_q + FILT_ADDR_LEN'(1);
               if (psum_done) state_d = last_win ? DONE : ADVANCE;
            end
            ADVANCE: begin
               base_d  = base_q + (IF_ADDR_LEN+1)'(s_q);
               tap_d   = '0;
               win_d   = win_q + IF_ADDR_LEN'(1);
               state_d = READ;
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         base_q  <= '0;
         tap_q   <= '0;
         win_q   <= '0;
         k_q     <= '0;
         s_q     <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         tap_q   <= tap_d;
         win_q   <= win_d;
         k_q     <= k_d;
         s_q     <= s_d;
         n_q     <= n_d;
      end
   end
endmodule

// File: tb/tb_conv_read_addr_gen.sv
// tb_conv_read_addr_gen: directed per-scenario checks of the row read-address walk
module tb_conv_read_addr_gen;
   logic       clk = 1'b0;
   logic       rst, clear, start_rd_gen, stall;
   logic [3:0] filt_len, stride;
   logic [4:0] if_len, if_wr_cnt;
   logic       rd_en, first_mac, psum_done, stride_pos_ld, full_done, busy;
   logic [3:0] if_raddr, filt_raddr, win_idx;
   int         cmp = 0, err = 0, cyc = 0;
   bit         rec = 0;
   logic [4:0] l_fl[64];
   logic [3:0] l_ia[64], l_fa[64], l_wi[64];
   logic       l_busy[64];

   conv_read_addr_gen dut (
      .clk(clk), .rst(rst), .clear(clear), .start_rd_gen(start_rd_gen),
      .filt_len(filt_len), .stride(stride), .if_len(if_len), .if_wr_cnt(if_wr_cnt),
      .stall(stall), .rd_en(rd_en), .if_raddr(if_raddr), .filt_raddr(filt_raddr),
      .first_mac(first_mac), .psum_done(psum_done), .stride_pos_ld(stride_pos_ld),
      .full_done(full_done), .win_idx(win_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   // cycle c of a row (c=1 is the cycle after the start edge) is logged at its falling edge
   always @(negedge clk) if (rec && cyc < 63) begin
      cyc++;
      l_fl[cyc]   = {rd_en, first_mac, psum_done, stride_pos_ld, full_done};
      l_ia[cyc]   = if_raddr;
      l_fa[cyc]   = filt_raddr;
      l_wi[cyc]   = win_idx;
      l_busy[cyc] = busy;
   end

   task automatic go(input logic [3:0] k, input logic [3:0] s, input logic [4:0] n, input logic [4:0] w);
      filt_len = k; stride = s; if_len = n; if_wr_cnt = w; start_rd_gen = 1'b1;
      @(posedge clk);
      cyc = 0; rec = 1;
      #1 start_rd_gen = 1'b0; filt_len = 4'd1; stride = 4'd7; if_len = 5'd2;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; clear = 1'b0; start_rd_gen = 1'b0; stall = 1'b0;
      filt_len = '0; stride = '0; if_len = '0; if_wr_cnt = '0;
      repeat (2) @(negedge clk);
      cmp++;
      if ({busy, rd_en, first_mac, psum_done, stride_pos_ld, full_done} !== 6'b0) begin
         err++; $display("FAIL reset_flags got %b exp 000000", {busy, rd_en, first_mac, psum_done, stride_pos_ld, full_done});
      end
      cmp++;
      if ({if_raddr, filt_raddr, win_idx} !== 12'h000) begin
         err++; $display("FAIL reset_addr got %h exp 000", {if_raddr, filt_raddr, win_idx});
      end
      rst = 1'b0;
      wait_cycles(1);
      cmp++;
      if (busy !== 1'b0) begin err++; $display("FAIL reset_idle busy got %b exp 0", busy); end
   endtask

   task automatic test_basic(input string tag);
      int fl[14], ia[14], fa[14];
      fl = '{0, 5'b11000, 5'b10000, 5'b10100, 5'b00010, 5'b11000, 5'b10000, 5'b10100,
             5'b00010, 5'b11000, 5'b10000, 5'b10100, 5'b00001, 0};
      ia = '{-1, 0, 1, 2, -1, 2, 3, 4, -1, 4, 5, 6, -1, -1};
      fa = '{-1, 0, 1, 2, -1, 0, 1, 2, -1, 0, 1, 2, -1, -1};
      go(4'd3, 4'd2, 5'd8, 5'd16);
      wait_cycles(13);
      for (int c = 1; c <= 13; c++) begin
         cmp++;
         if (l_fl[c] !== 5'(fl[c])) begin err++; $display("FAIL %s c%0d flags got %b exp %b", tag, c, l_fl[c], 5'(fl[c])); end
         if (ia[c] >= 0) begin
            cmp++;
            if (l_ia[c] !== 4'(ia[c]) || l_fa[c] !== 4'(fa[c])) begin
               err++; $display("FAIL %s c%0d addr got %0d/%0d exp %0d/%0d", tag, c, l_ia[c], l_fa[c], ia[c], fa[c]);
            end
         end
      end
      cmp++;
      if (l_wi[11] !== 4'd2) begin err++; $display("FAIL %s win_idx got %0d exp 2", tag, l_wi[11]); end
      cmp++;
      if (l_busy[13] !== 1'b0) begin err++; $display("FAIL %s end_busy got %b exp 0", tag, l_busy[13]); end
   endtask

   task automatic test_k1;
      logic [4:0] ef;
      go(4'd1, 4'd1, 5'd5, 5'd16);
      wait_cycles(11);
      for (int c = 1; c <= 11; c++) begin
         ef = (c == 11) ? 5'b0 : (c == 10) ? 5'b00001 : (c % 2 == 1) ? 5'b11100 : 5'b00010;
         cmp++;
         if (l_fl[c] !== ef) begin err++; $display("FAIL k1 c%0d flags got %b exp %b", c, l_fl[c], ef); end
         if (c % 2 == 1 && c < 10) begin
            cmp++;
            if (l_ia[c] !== 4'((c - 1) / 2) || l_fa[c] !== 4'd0) begin
               err++; $display("FAIL k1 c%0d addr got %0d/%0d exp %0d/0", c, l_ia[c], l_fa[c], (c - 1) / 2);
            end
         end
      end
      cmp++;
      if (l_wi[9] !== 4'd4) begin err++; $display("FAIL k1 win_idx got %0d exp 4", l_wi[9]); end
   endtask

   task automatic test_avail;
      int fl[11], ia[11], fa[11];
      fl = '{0, 5'b11000, 0, 0, 0, 5'b10100, 5'b00010, 5'b11000, 5'b10100, 5'b00001, 0};
      ia = '{-1, 0, -1, -1, -1, 1, -1, 2, 3, -1, -1};
      fa = '{-1, 0, -1, -1, -1, 1, -1, 0, 1, -1, -1};
      go(4'd2, 4'd2, 5'd4, 5'd1);
      wait_cycles(4);
      @(posedge clk);
      #1 if_wr_cnt = 5'd4;
      wait_cycles(6);
      for (int c = 1; c <= 10; c++) begin
         cmp++;
         if (l_fl[c] !== 5'(fl[c])) begin err++; $display("FAIL avail c%0d flags got %b exp %b", c, l_fl[c], 5'(fl[c])); end
         if (ia[c] >= 0) begin
            cmp++;
            if (l_ia[c] !== 4'(ia[c]) || l_fa[c] !== 4'(fa[c])) begin
               err++; $display("FAIL avail c%0d addr got %0d/%0d exp %0d/%0d", c, l_ia[c], l_fa[c], ia[c], fa[c]);
            end
         end
      end
      cmp++;
      if ({l_busy[2], l_busy[3], l_busy[4], l_busy[10]} !== 4'b1110) begin
         err++; $display("FAIL avail busy got %b exp 1110", {l_busy[2], l_busy[3], l_busy[4], l_busy[10]});
      end
   endtask

   task automatic test_stall;
      int fl[17], ia[17], fa[17];
      fl = '{0, 5'b11000, 5'b10000, 5'b10100, 5'b00010, 5'b11000, 0, 0, 0, 5'b10000, 5'b10100,
             5'b00010, 5'b11000, 5'b10000, 5'b10100, 5'b00001, 0};
      ia = '{-1, 0, 1, 2, -1, 2, 3, 3, 3, 3, 4, -1, 4, 5, 6, -1, -1};
      fa = '{-1, 0, 1, 2, -1, 0, 1, 1, 1, 1, 2, -1, 0, 1, 2, -1, -1};
      go(4'd3, 4'd2, 5'd8, 5'd16);
      wait_cycles(5);
      @(posedge clk);
      #1 stall = 1'b1;
      wait_cycles(3);
      @(posedge clk);
      #1 stall = 1'b0;
      wait_cycles(8);
      for (int c = 1; c <= 16; c++) begin
         cmp++;
         if (l_fl[c] !== 5'(fl[c])) begin err++; $display("FAIL stall c%0d flags got %b exp %b", c, l_fl[c], 5'(fl[c])); end
         if (ia[c] >= 0) begin
            cmp++;
            if (l_ia[c] !== 4'(ia[c]) || l_fa[c] !== 4'(fa[c])) begin
               err++; $display("FAIL stall c%0d addr got %0d/%0d exp %0d/%0d", c, l_ia[c], l_fa[c], ia[c], fa[c]);
            end
         end
      end
   endtask

   task automatic test_invalid;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) go(4'd6, 4'd2, 5'd4, 5'd16);
         else go(4'd2, 4'd0, 5'd4, 5'd16);
         wait_cycles(2);
         cmp++;
         if (l_fl[1] !== 5'b00001 || l_busy[1] !== 1'b1) begin
            err++; $display("FAIL invalid%0d c1 flags/busy got %b/%b exp 00001/1", i, l_fl[1], l_busy[1]);
         end
         cmp++;
         if (l_fl[2] !== 5'b0 || l_busy[2] !== 1'b0) begin
            err++; $display("FAIL invalid%0d c2 flags/busy got %b/%b exp 00000/0", i, l_fl[2], l_busy[2]);
         end
      end
   endtask

   task automatic test_clear;
      go(4'd3, 4'd2, 5'd8, 5'd16);
      wait_cycles(2);
      @(posedge clk);
      #1 clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      wait_cycles(8);
      for (int c = 4; c <= 11; c++) begin
         cmp++;
         if (l_fl[c] !== 5'b0 || l_busy[c] !== 1'b0) begin
            err++; $display("FAIL clear c%0d flags/busy got %b/%b exp 00000/0", c, l_fl[c], l_busy[c]);
         end
      end
   endtask

   task automatic test_rst_mid;
      go(4'd3, 4'd2, 5'd8, 5'd16);
      wait_cycles(2);
      rst = 1'b1;
      #1;
      cmp++;
      if ({busy, rd_en, first_mac, psum_done, stride_pos_ld, full_done, if_raddr, filt_raddr, win_idx} !== 18'b0) begin
         err++; $display("FAIL rst_mid outputs got %b exp 0", {busy, rd_en, first_mac, psum_done, stride_pos_ld, full_done, if_raddr, filt_raddr, win_idx});
      end
      @(negedge clk);
      rst = 1'b0;
      wait_cycles(2);
      cmp++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin err++; $display("FAIL rst_mid idle got %b%b exp 00", busy, rd_en); end
   endtask

   initial begin
      test_reset;
      test_basic("basic");
      test_k1;
      test_avail;
      test_stall;
      test_invalid;
      test_clear;
      test_basic("after_clear");
      test_rst_mid;
      test_basic("after_rst");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule

// File: doc/conv_read_addr_gen.md
# conv_read_addr_gen

Read-address generator for the PE datapath. It responds to the PE controller's `start_rd_gen` request and walks the IF and filter scratchpads for one row. For each sliding window it issues `K` tap reads, then moves the window base by the stride. It returns the `psum_done`, `stride_pos_ld` and `full_done` status pulses that the controller uses to sequence its modes.

## Interface
Parameters:
- `IF_ADDR_LEN`, 4: IF scratchpad address width; row length is at most 2^IF_ADDR_LEN.
- `FILT_ADDR_LEN`, 4: filter scratchpad address width.
- `STRIDE_W`, 4: stride field width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clear`  in  1  synchronous clear, driven by the controller's `reset_all`.
- `start_rd_gen`  in  1  start request; sampled only in IDLE.
- `filt_len`  in  FILT_ADDR_LEN  filter length K.
- `stride`  in  STRIDE_W  stride S.
- `if_len`  in  IF_ADDR_LEN+1  row length N.
- `if_wr_cnt`  in  IF_ADDR_LEN+1  number of IF words already written to the scratchpad.
- `stall`  in  1  downstream (psum buffer full) hold.
- `rd_en`  out  1  scratchpad read strobe.
- `if_raddr`  out  IF_ADDR_LEN  IF read address.
- `filt_raddr`  out  FILT_ADDR_LEN  filter read address.
- `first_mac`  out  1  marks tap 0 of a window; accumulator load.
- `psum_done`  out  1  marks the last tap of a window.
- `stride_pos_ld`  out  1  window base advance pulse.
- `full_done`  out  1  row complete pulse.
- `win_idx`  out  IF_ADDR_LEN  index of the current window.
- `busy`  out  1  high in every state except IDLE.

## Operation
State is held in registers. Outputs are decoded combinationally from the state, the counters and the `stall`/`if_wr_cnt` inputs.

Registers:
- `base` (IF_ADDR_LEN+1 bits).
- `tap` (FILT_ADDR_LEN bits).
- `win_idx`.
- Latched copies of K, S and N, captured on start.

Configuration is valid when K≥1, S≥1 and K≤N.

States:
- IDLE: all outputs 0.
  - `start_rd_gen` with a valid configuration → READ. Latch K, S, N; set base=0, tap=0, win_idx=0.
  - `start_rd_gen` with an invalid configuration → DONE. No reads are issued.
- READ: the tap is available when `base+tap < if_wr_cnt`.
  - `rd_en` = `~stall & available`.
  - `if_raddr` = `base+tap`, truncated to IF_ADDR_LEN bits. This is lossless because `base+tap < N`.
  - `filt_raddr` = `tap`.
  - `first_mac` = `rd_en & tap==0`.
  - `psum_done` = `rd_en & tap==K-1`.
  - On `rd_en`: tap increments.
  - On `psum_done`: if `base+S+K ≤ N` → ADVANCE, otherwise → DONE.
  - The `base+S+K` sum is computed IF_ADDR_LEN+2 bits wide, so it never wraps.
  - With `rd_en`=0, all registers hold.
- ADVANCE: one cycle.
  - `stride_pos_ld`=1.
  - base += S, tap=0, win_idx+1.
  - → READ.
- DONE: one cycle.
  - `full_done`=1.
  - → IDLE.

Priority order: `rst` > `clear` > FSM.
- `clear` in any state → IDLE, with all counters zeroed. No pulse is emitted in that cycle.
- `start_rd_gen` outside IDLE is ignored.
- Changes to `filt_len`, `stride` or `if_len` mid-row have no effect; the latched copies are used.

## Timing
- Reset values: state IDLE; base, tap and win_idx 0. Every output is 0, including `busy`, `rd_en` and all pulses.
- Latency: with `start_rd_gen` sampled at edge t0, the first `rd_en` is in cycle t0+1, provided data is available and `stall`=0.
- Throughput: one tap per cycle.
- Windows W = floor((N−K)/S)+1.
- Row length with no stalls: W·K + (W−1) + 1 cycles after the start edge. `full_done` occurs in the final cycle.
- A stall or a data-not-available cycle stretches READ by exactly one cycle.
- `stride_pos_ld` and `full_done` are never asserted in the same cycle as `rd_en`.
- `psum_done` and `first_mac` coincide when K=1.
- Window overlap (S<K) and gapped windows (S>K) are both legal.
- Scratchpad read data is returned one cycle after `rd_en`; that is the scratchpad's own timing, not this block's.

## Test plan
- N=8, K=3, S=2, no stalls, start at t0:
  - `rd_en` in t1–t3, t5–t7 and t9–t11.
  - `if_raddr` sequence 0,1,2 / 2,3,4 / 4,5,6.
  - `filt_raddr` sequence 0,1,2 repeated.
  - `stride_pos_ld` at t4 and t8; `full_done` at t12; 3 `psum_done` pulses; `win_idx` ends at 2.
- N=5, K=1, S=1:
  - 5 reads.
  - `first_mac`=`psum_done`=1 on each read.
  - 4 `stride_pos_ld` pulses, then `full_done`.
- Data availability: `if_wr_cnt`=1 when started with N=4, K=2, S=2.
  - `rd_en` for address 0 only, then held.
  - Raising `if_wr_cnt` to 4 resumes at address 1 with no skipped or duplicated address.
- `stall` high for 3 cycles in the middle of window 2 (N=8, K=3, S=2):
  - Addresses hold, no pulses are emitted, and the sequence resumes intact.
  - `full_done` moves out by 3 cycles.
- Invalid configuration: K=6, N=4.
  - `full_done` in the cycle after start, with zero `rd_en`.
  - S=0 gives the same result.
- `clear` asserted during READ:
  - IDLE on the next cycle, no `full_done`.
  - A new start behaves exactly like the first run.
  - Asserting `rst` mid-row forces all outputs to 0 immediately.
